// File: rtl/write_back_unit_pkg.sv
// write_back_unit_pkg: shared constants for the write-back stage
package simple_pkg;
  localparam int WIDTH = 16;
  localparam int NREG = 8;
  localparam logic [2:0] PHASE_WB = 3'b100;
  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_MDR = 1'b1;
endpackage

// File: rtl/write_back_unit_if.sv
// write_back_unit_if: output-port valid/ready handshake bundle
interface write_back_unit_if import simple_pkg::*; #(parameter int W = WIDTH) ();
  logic [W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master(output out_data, out_valid, input out_ready);
  modport slave(input out_data, out_valid, output out_ready);
endinterface

// File: rtl/write_back_unit_reg_file.sv
// write_back_unit_reg_file: NREGxWIDTH register file, one write port, two combinational read ports
module write_back_unit_reg_file import simple_pkg::*; #(
  parameter int W = WIDTH,
  parameter int N = NREG,
  parameter int AW = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_a,
  output logic [W-1:0]  rdata_b
);
  logic [N-1:0][W-1:0] mem_q, mem_d;
  // next array contents: single write, r0 included
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  // array state with synchronous clear
  always_ff @(posedge clock) mem_q <= reset ? '0 : mem_d;
  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];
endmodule

// File: rtl/write_back_unit.sv
// write_back_unit: commits ALU/MDR results, SZCV flags and OUT data; optional WB_BYPASS_EN read forwarding
module write_back_unit import simple_pkg::*; #(
  parameter int W = WIDTH,
  parameter int N = NREG
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           phase_counter,
  input  logic                 wb_en,
  input  logic                 wb_sel,
  input  logic [$clog2(N)-1:0] wb_addr,
  input  logic [W-1:0]         alu_result,
  input  logic [W-1:0]         mdr_data,
  input  logic                 flag_en,
  input  logic [3:0]           flags_in,
  input  logic                 out_en,
  input  logic [$clog2(N)-1:0] rd_addr_a,
  input  logic [$clog2(N)-1:0] rd_addr_b,
  output logic [W-1:0]         rd_data_a,
  output logic [W-1:0]         rd_data_b,
  output logic [3:0]           flags,
  output logic                 busy,
  write_back_unit_if.master    out_if
);
  logic in_wb, commit, wr_en, out_valid_q, out_valid_d;
  logic [W-1:0] wr_data, arr_a, arr_b, out_data_q, out_data_d;
  logic [3:0] flags_q, flags_d;
  // stall while an unaccepted OUT blocks a new one; otherwise commit in the write-back phase
  always_comb begin
    in_wb = phase_counter == PHASE_WB;
    busy = out_valid_q && !out_if.out_ready && out_en && in_wb;
    commit = in_wb && !busy;
    wr_en = commit && wb_en;
    wr_data = wb_sel == WB_SRC_MDR ? mdr_data : alu_result;
    flags_d = commit && flag_en ? flags_in : flags_q;
    out_data_d = commit && out_en ? alu_result : out_data_q;
    out_valid_d = commit && out_en ? 1'b1 : out_valid_q && !out_if.out_ready;
  end
  // flag and output-port state
  always_ff @(posedge clock) begin
    flags_q <= reset ? '0 : flags_d;
    out_data_q <= reset ? '0 : out_data_d;
    out_valid_q <= reset ? 1'b0 : out_valid_d;
  end
  write_back_unit_reg_file #(.W(W), .N(N)) u_rf (
    .clock(clock), .reset(reset), .we(wr_en), .waddr(wb_addr), .wdata(wr_data),
    .raddr_a(rd_addr_a), .raddr_b(rd_addr_b), .rdata_a(arr_a), .rdata_b(arr_b)
  );
`ifdef WB_BYPASS_EN
  assign rd_data_a = wr_en && rd_addr_a == wb_addr ? wr_data : arr_a;
  assign rd_data_b = wr_en && rd_addr_b == wb_addr ? wr_data : arr_b;
`else
  assign rd_data_a = arr_a;
  assign rd_data_b = arr_b;
`endif
  assign flags = flags_q;
  assign out_if.out_data = out_data_q;
  assign out_if.out_valid = out_valid_q;
endmodule

// File: tb/tb_write_back_unit.sv
// tb_write_back_unit: directed vectors, output-port scoreboard
module tb_write_back_unit;
  logic clock = 0, reset = 1;
  logic [2:0] phase_counter = 0, wb_addr = 0, rd_addr_a = 0, rd_addr_b = 0;
  logic wb_en = 0, wb_sel = 0, flag_en = 0, out_en = 0, busy;
  logic [15:0] alu_result = 0, mdr_data = 0, rd_data_a, rd_data_b;
  logic [3:0] flags_in = 0, flags;
  int n_chk = 0, n_fail = 0;
  logic [15:0] exp_q[$];
  write_back_unit_if ifc ();
  write_back_unit dut (
    .clock(clock), .reset(reset), .phase_counter(phase_counter), .wb_en(wb_en), .wb_sel(wb_sel),
    .wb_addr(wb_addr), .alu_result(alu_result), .mdr_data(mdr_data), .flag_en(flag_en),
    .flags_in(flags_in), .out_en(out_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .flags(flags), .busy(busy), .out_if(ifc)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    phase_counter = 0; wb_en = 0; wb_sel = 0; flag_en = 0; out_en = 0;
  endtask
  // monitor: every accepted transfer must match the oldest issued OUT
  always @(negedge clock) begin
    if (!reset && ifc.out_valid && ifc.out_ready) begin
      if (exp_q.size() == 0) chk("xfer_unexpected", ifc.out_data, 16'hxxxx);
      else chk("xfer_data", ifc.out_data, exp_q.pop_front());
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    ifc.out_ready = 0;
    tick(); tick();
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i); #1;
      chk("reset_rd_a", rd_data_a, 0);
      chk("reset_rd_b", rd_data_b, 0);
    end
    chk("reset_flags", 16'(flags), 0);
    chk("reset_valid", 16'(ifc.out_valid), 0);
    chk("reset_busy", 16'(busy), 0);
    phase_counter = 3'b100; wb_en = 1; wb_addr = 5; alu_result = 16'h1234; rd_addr_a = 5; #1;
`ifdef WB_BYPASS_EN
    chk("alu_wb_same_cycle", rd_data_a, 16'h1234);
`else
    chk("alu_wb_same_cycle", rd_data_a, 0);
`endif
    tick(); idle(); #1;
    chk("alu_wb", rd_data_a, 16'h1234);
    phase_counter = 3'b011; wb_en = 1; alu_result = 16'h9999; flag_en = 1; flags_in = 4'hF; out_en = 1;
    tick(); idle(); #1;
    chk("wrong_phase_reg", rd_data_a, 16'h1234);
    chk("wrong_phase_flags", 16'(flags), 0);
    chk("wrong_phase_valid", 16'(ifc.out_valid), 0);
    phase_counter = 3'b100; wb_en = 1; wb_sel = 1; wb_addr = 2; mdr_data = 16'hBEEF; alu_result = 16'h7777;
    flag_en = 1; flags_in = 4'b1010;
    tick(); idle(); rd_addr_b = 2; #1;
    chk("load_wb", rd_data_b, 16'hBEEF);
    chk("load_flags", 16'(flags), 16'h000A);
    phase_counter = 3'b100; wb_en = 1; wb_addr = 0; alu_result = 16'h0F0F;
    tick(); idle(); rd_addr_a = 0; #1;
    chk("r0_writable", rd_data_a, 16'h0F0F);
    phase_counter = 3'b100; out_en = 1; alu_result = 16'h00AA; exp_q.push_back(16'h00AA);
    tick(); #1;
    chk("out1_valid", 16'(ifc.out_valid), 1);
    chk("out1_data", ifc.out_data, 16'h00AA);
    alu_result = 16'h00BB; wb_en = 1; wb_addr = 6; rd_addr_a = 6; #1;
    chk("stall_busy", 16'(busy), 1);
    chk("stall_no_bypass", rd_data_a, 0);
    tick();
    chk("stall_hold_data", ifc.out_data, 16'h00AA);
    chk("stall_no_write", rd_data_a, 0);
    chk("stall_busy_held", 16'(busy), 1);
    ifc.out_ready = 1; #1;
    chk("release_busy", 16'(busy), 0);
    exp_q.push_back(16'h00BB);
    tick(); idle(); #1;
    chk("chain_valid", 16'(ifc.out_valid), 1);
    chk("chain_data", ifc.out_data, 16'h00BB);
    chk("chain_write", rd_data_a, 16'h00BB);
    tick();
    chk("drain_valid", 16'(ifc.out_valid), 0);
    for (int i = 0; i < 2; i++) begin
      phase_counter = 3'b100; out_en = 1; alu_result = 16'h0011 * 16'(i + 1);
      exp_q.push_back(alu_result); #1;
      chk("stream_busy", 16'(busy), 0);
      tick(); idle();
    end
    tick();
    chk("stream_drained", 16'(ifc.out_valid), 0);
    phase_counter = 3'b100; wb_en = 1; wb_addr = 3; alu_result = 16'h5555; rd_addr_b = 3; rd_addr_a = 5; #1;
`ifdef WB_BYPASS_EN
    chk("bypass_b", rd_data_b, 16'h5555);
`else
    chk("bypass_b", rd_data_b, 0);
`endif
    chk("bypass_a_other", rd_data_a, 16'h1234);
    tick(); idle(); #1;
    chk("bypass_after", rd_data_b, 16'h5555);
    ifc.out_ready = 0;
    phase_counter = 3'b100; out_en = 1; alu_result = 16'h00CC;
    tick();
    alu_result = 16'h00DD; wb_en = 1; wb_addr = 7; rd_addr_a = 7; #1;
    chk("pre_reset_busy", 16'(busy), 1);
    reset = 1;
    tick(); #1;
    chk("mid_reset_valid", 16'(ifc.out_valid), 0);
    chk("mid_reset_busy", 16'(busy), 0);
    reset = 0; idle(); rd_addr_b = 5; #1;
    chk("mid_reset_no_write", rd_data_a, 0);
    chk("mid_reset_regs", rd_data_b, 0);
    chk("mid_reset_data", ifc.out_data, 0);
    tick(); tick();
    chk("scoreboard_empty", 16'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
